// File: rtl/jtag_bridge_pkg.sv
// ---------------------------------------------------------------------------
// jtag_bridge_pkg
// Shared definitions for the JTAG-to-register bridge: FSM state encoding,
// command/response word field layout and startup guard length.
// No ports (package).
// ---------------------------------------------------------------------------
package jtag_bridge_pkg;

  // Bridge sequencer states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } bridge_state_e;

  // Command word: {cmd_toggle, rnw, addr[ADDR_W], wdata[DATA_W]}.
  // The control field sits above addr+wdata; offsets are within that field.
  localparam int CMD_CTRL_W  = 2;
  localparam int CMD_TOG_OFS = 1;
  localparam int CMD_RNW_OFS = 0;
  localparam int WDATA_LSB   = 0;

  // Response word: {resp_toggle, overrun, err, rdata[DATA_W]}.
  // The control field sits above rdata; offsets are within that field.
  localparam int RESP_CTRL_W  = 3;
  localparam int RESP_TOG_OFS = 2;
  localparam int RESP_OVR_OFS = 1;
  localparam int RESP_ERR_OFS = 0;
  localparam int RDATA_LSB    = 0;

  // Edges after reset release during which command detection is masked.
  localparam int WARMUP_EDGES = 3;

  function automatic int cmd_width(input int addr_w, input int data_w);
    return addr_w + data_w + CMD_CTRL_W;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + RESP_CTRL_W;
  endfunction

endpackage

// File: rtl/jtag_reg_bridge_if.sv
// ---------------------------------------------------------------------------
// jtag_reg_bridge_if
// Simple request/acknowledge register bus between the bridge and a target.
//   bus_req   : access request (master -> slave)
//   bus_we    : write when high (master -> slave)
//   bus_addr  : access address (master -> slave)
//   bus_wdata : write data (master -> slave)
//   bus_ack   : access complete (slave -> master)
//   bus_rdata : read data, valid with bus_ack (slave -> master)
// ---------------------------------------------------------------------------
interface jtag_reg_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/jtag_bridge_sync.sv
// ---------------------------------------------------------------------------
// jtag_bridge_sync
// Two-stage flip-flop synchronizer, parameterized width, async reset to 0.
//   CLK   : destination clock
//   RST_N : asynchronous active-low reset
//   d     : asynchronous input vector
//   q     : synchronized output (second stage)
// ---------------------------------------------------------------------------
module jtag_bridge_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_r;

  // First and second synchronizer stages.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_r <= {WIDTH{1'b0}};
      q    <= {WIDTH{1'b0}};
    end else begin
      s1_r <= d;
      q    <= s1_r;
    end
  end

endmodule

// File: rtl/jtag_reg_bridge.sv
// ---------------------------------------------------------------------------
// jtag_reg_bridge
// Turns toggle-handshaked command words from a JTAG user register (another
// clock domain) into single accesses on a req/ack register bus, and returns
// a toggle-handshaked response word.
//   CLK          : bridge clock, all state on its rising edge
//   RST_N        : asynchronous active-low reset
//   jtag_in_reg  : {cmd_toggle, rnw, addr, wdata}, asynchronous
//   jtag_out_reg : {resp_toggle, overrun, err, rdata}
//   bus          : register bus master (req/we/addr/wdata out, ack/rdata in)
// Optional feature: define JTAG_BRIDGE_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES edges without ack (err = 1, rdata all-ones).
// ---------------------------------------------------------------------------
module jtag_reg_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [ADDR_W+DATA_W+CMD_CTRL_W-1:0] jtag_in_reg,
  output logic [DATA_W+RESP_CTRL_W-1:0]       jtag_out_reg,
  jtag_reg_bridge_if.master                   bus
);

  localparam int CMD_W  = cmd_width(ADDR_W, DATA_W);
  localparam int CTRL_B = ADDR_W + DATA_W;

  // Synchronized command word and its fields.
  logic [CMD_W-1:0]  s2_s;
  logic              s2_tog_s;
  logic              s2_rnw_s;
  logic [ADDR_W-1:0] s2_addr_s;
  logic [DATA_W-1:0] s2_wdata_s;

  logic              s3_tog_r;
  logic [1:0]        warm_r;
  logic              new_cmd_s;

  bridge_state_e     state_r;
  bridge_state_e     state_n;

  logic              pend_r;
  logic              pend_tog_r;
  logic              pend_rnw_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic [DATA_W-1:0] pend_wdata_r;
  logic              ovr_r;
  logic              cmd_tog_r;
  logic              cmd_rnw_r;

  logic              start_s;
  logic              take_pend_s;
  logic              finish_s;
  logic              timeout_s;
  logic              tmo_hit_s;
  logic              pend_load_s;
  logic              pend_clear_s;
  logic              ovr_set_s;

  logic              iss_tog_s;
  logic              iss_rnw_s;
  logic [ADDR_W-1:0] iss_addr_s;
  logic [DATA_W-1:0] iss_wdata_s;
  logic [DATA_W-1:0] resp_rdata_s;
  logic [DATA_W+RESP_CTRL_W-1:0] resp_word_s;

  jtag_bridge_sync #(.WIDTH(CMD_W)) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (jtag_in_reg),
    .q     (s2_s)
  );

  assign s2_tog_s   = s2_s[CTRL_B + CMD_TOG_OFS];
  assign s2_rnw_s   = s2_s[CTRL_B + CMD_RNW_OFS];
  assign s2_addr_s  = s2_s[DATA_W +: ADDR_W];
  assign s2_wdata_s = s2_s[WDATA_LSB +: DATA_W];

  // Edge detection is masked until the synchronizer chain has refilled, so a
  // toggle left high across reset does not look like a fresh command.
  assign new_cmd_s = (warm_r == 2'(WARMUP_EDGES)) && (s2_tog_s != s3_tog_r);

`ifdef JTAG_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Counts edges spent in REQ for the current access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (start_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_REQ) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign tmo_hit_s = (state_r == ST_REQ) &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit_s = 1'b0;
`endif

  // Third toggle stage and startup guard counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s3_tog_r <= 1'b0;
      warm_r   <= 2'd0;
    end else begin
      s3_tog_r <= s2_tog_s;
      if (warm_r != 2'(WARMUP_EDGES)) begin
        warm_r <= warm_r + 2'd1;
      end else begin
        warm_r <= warm_r;
      end
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_n      = state_r;
    start_s      = 1'b0;
    take_pend_s  = 1'b0;
    finish_s     = 1'b0;
    timeout_s    = 1'b0;
    pend_load_s  = 1'b0;
    pend_clear_s = 1'b0;
    ovr_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pend_r) begin
          // Pending command goes first; a simultaneous new one refills the slot.
          start_s     = 1'b1;
          take_pend_s = 1'b1;
          state_n     = ST_REQ;
          if (new_cmd_s) begin
            pend_load_s = 1'b1;
          end else begin
            pend_clear_s = 1'b1;
          end
        end else if (new_cmd_s) begin
          start_s = 1'b1;
          state_n = ST_REQ;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (new_cmd_s) begin
          if (pend_r) begin
            ovr_set_s = 1'b1;
          end else begin
            pend_load_s = 1'b1;
          end
        end else begin
          ovr_set_s = 1'b0;
        end
        if (bus.bus_ack) begin
          finish_s = 1'b1;
          state_n  = ST_IDLE;
        end else if (tmo_hit_s) begin
          finish_s  = 1'b1;
          timeout_s = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          state_n = ST_REQ;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Issue-field selection and response word assembly.
  always_comb begin
    iss_tog_s    = s2_tog_s;
    iss_rnw_s    = s2_rnw_s;
    iss_addr_s   = s2_addr_s;
    iss_wdata_s  = s2_wdata_s;
    resp_rdata_s = {DATA_W{1'b0}};
    if (take_pend_s) begin
      iss_tog_s   = pend_tog_r;
      iss_rnw_s   = pend_rnw_r;
      iss_addr_s  = pend_addr_r;
      iss_wdata_s = pend_wdata_r;
    end else begin
      iss_tog_s   = s2_tog_s;
    end
    if (timeout_s) begin
      resp_rdata_s = {DATA_W{1'b1}};
    end else if (cmd_rnw_r) begin
      resp_rdata_s = bus.bus_rdata;
    end else begin
      resp_rdata_s = {DATA_W{1'b0}};
    end
    // An overrun arriving on the completion edge is reported right away.
    resp_word_s = {cmd_tog_r, ovr_r | ovr_set_s, timeout_s, resp_rdata_s};
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // One-deep pending slot and sticky overrun flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_r       <= 1'b0;
      pend_tog_r   <= 1'b0;
      pend_rnw_r   <= 1'b0;
      pend_addr_r  <= {ADDR_W{1'b0}};
      pend_wdata_r <= {DATA_W{1'b0}};
      ovr_r        <= 1'b0;
    end else begin
      if (pend_load_s) begin
        pend_r       <= 1'b1;
        pend_tog_r   <= s2_tog_s;
        pend_rnw_r   <= s2_rnw_s;
        pend_addr_r  <= s2_addr_s;
        pend_wdata_r <= s2_wdata_s;
      end else if (pend_clear_s) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
      if (finish_s) begin
        ovr_r <= 1'b0;
      end else if (ovr_set_s) begin
        ovr_r <= 1'b1;
      end else begin
        ovr_r <= ovr_r;
      end
    end
  end

  // Bus request and its registered address/data/direction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= {ADDR_W{1'b0}};
      bus.bus_wdata <= {DATA_W{1'b0}};
      cmd_tog_r     <= 1'b0;
      cmd_rnw_r     <= 1'b0;
    end else if (start_s) begin
      bus.bus_req   <= 1'b1;
      bus.bus_we    <= ~iss_rnw_s;
      bus.bus_addr  <= iss_addr_s;
      bus.bus_wdata <= iss_wdata_s;
      cmd_tog_r     <= iss_tog_s;
      cmd_rnw_r     <= iss_rnw_s;
    end else if (finish_s) begin
      bus.bus_req   <= 1'b0;
    end else begin
      bus.bus_req   <= bus.bus_req;
    end
  end

  // Response word, updated once per completed access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      jtag_out_reg <= {(DATA_W+RESP_CTRL_W){1'b0}};
    end else if (finish_s) begin
      jtag_out_reg <= resp_word_s;
    end else begin
      jtag_out_reg <= jtag_out_reg;
    end
  end

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_jtag_reg_bridge
// Self-checking bench for jtag_reg_bridge: directed read/write, random
// accesses, pending/overrun, long wait (timeout when JTAG_BRIDGE_TIMEOUT_EN
// is defined) and reset during an access.
// ---------------------------------------------------------------------------
module tb_jtag_reg_bridge;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b1;
  logic [AW+DW+1:0] jtag_in_reg = '0;
  logic [DW+2:0]    jtag_out_reg;
  logic             host_tog = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;

  jtag_reg_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  jtag_reg_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .jtag_in_reg  (jtag_in_reg),
    .jtag_out_reg (jtag_out_reg),
    .bus          (bus_if)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: response word the host should see for a completed access.
  function automatic logic [DW+2:0] model_resp(input logic tog, input logic ovr, input logic err,
                                               input logic rnw, input logic [DW-1:0] rd);
    logic [DW-1:0] data;
    if (err) data = {DW{1'b1}};
    else if (rnw) data = rd;
    else data = '0;
    return {tog, ovr, err, data};
  endfunction

  task automatic send_cmd(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_tog = ~host_tog;
    jtag_in_reg = {host_tog, rnw, a, d};
  endtask

  // One isolated access: latency, field stability, ack timing and response.
  task automatic run_access(input string tag, input logic rnw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] rd,
                            input int delay, input logic exp_ovr);
    logic ok;
    send_cmd(rnw, a, d);
    @(negedge CLK); check({tag, "_lat1"}, 64'(bus_if.bus_req), 64'd0);
    @(negedge CLK); check({tag, "_lat2"}, 64'(bus_if.bus_req), 64'd0);
    @(negedge CLK); check({tag, "_req"}, 64'(bus_if.bus_req), 64'd1);
    check({tag, "_we"}, 64'(bus_if.bus_we), 64'(!rnw));
    check({tag, "_addr"}, 64'(bus_if.bus_addr), 64'(a));
    check({tag, "_wdata"}, 64'(bus_if.bus_wdata), 64'(d));
    ok = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge CLK);
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== a || bus_if.bus_we !== !rnw ||
          bus_if.bus_wdata !== d) ok = 1'b0;
    end
    check({tag, "_hold"}, 64'(ok), 64'd1);
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = rd;
    @(negedge CLK);
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = $urandom;
    check({tag, "_drop"}, 64'(bus_if.bus_req), 64'd0);
    check({tag, "_resp"}, 64'(jtag_out_reg), 64'(model_resp(host_tog, exp_ovr, 1'b0, rnw, rd)));
  endtask

  initial begin
    logic ok;
    logic tog_a, tog_b;
    logic [DW-1:0] rd_b;
    logic [AW-1:0] a_a, a_b, a_c;
    logic [DW-1:0] d_a, d_b, d_c;
    logic [DW+2:0] held;
    int cnt;

    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;

    // Reset state.
    #2 RST_N = 1'b0;
    #1;
    check("rst_req", 64'(bus_if.bus_req), 64'd0);
    check("rst_out", 64'(jtag_out_reg), 64'd0);
    check("rst_bus", 64'({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}), 64'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    check("idle_req", 64'(bus_if.bus_req), 64'd0);

    // Directed read and write.
    run_access("read", 1'b1, 16'h0010, 32'h0, 32'h12345678, 4, 1'b0);
    check("read_word", 64'(jtag_out_reg), 64'({1'b1, 1'b0, 1'b0, 32'h12345678}));
    run_access("write", 1'b0, 16'h0004, 32'hCAFEF00D, 32'hDEADBEEF, 2, 1'b0);

    // Random accesses.
    for (int i = 0; i < 20; i++) begin
      run_access("rand", 1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom),
                 32'($urandom), int'($urandom_range(0, 6)), 1'b0);
    end

    // Pending and overrun: two further toggles while the first access waits.
    a_a = 16'($urandom); a_b = 16'($urandom); a_c = 16'($urandom);
    d_a = 32'($urandom); d_b = 32'($urandom); d_c = 32'($urandom);
    rd_b = 32'($urandom);
    send_cmd(1'b0, a_a, d_a); tog_a = host_tog;
    repeat (3) @(negedge CLK);
    check("ovr_req_a", 64'(bus_if.bus_req), 64'd1);
    @(negedge CLK);
    send_cmd(1'b1, a_b, d_b); tog_b = host_tog;
    repeat (4) @(negedge CLK);
    send_cmd(1'b0, a_c, d_c);
    repeat (6) @(negedge CLK);
    check("ovr_hold_a", 64'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr}), 64'({2'b11, a_a}));
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'($urandom);
    @(negedge CLK);
    bus_if.bus_ack = 1'b0;
    check("ovr_gap", 64'(bus_if.bus_req), 64'd0);
    check("ovr_resp_a", 64'(jtag_out_reg), 64'(model_resp(tog_a, 1'b1, 1'b0, 1'b0, 32'h0)));
    @(negedge CLK);
    check("ovr_req_b", 64'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}),
          64'({2'b10, a_b, d_b}));
    repeat (2) @(negedge CLK);
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = rd_b;
    @(negedge CLK);
    bus_if.bus_ack = 1'b0;
    check("ovr_resp_b", 64'(jtag_out_reg), 64'(model_resp(tog_b, 1'b0, 1'b0, 1'b1, rd_b)));
    ok = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (bus_if.bus_req !== 1'b0) ok = 1'b0;
    end
    check("ovr_dropped", 64'(ok), 64'd1);
    run_access("ovr_next", 1'b1, 16'($urandom), 32'($urandom), 32'($urandom), 1, 1'b0);

    // Access with no timely ack.
`ifdef JTAG_BRIDGE_TIMEOUT_EN
    send_cmd(1'b1, 16'h0100, 32'h0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (bus_if.bus_req === 1'b1) cnt++;
    end
    check("tmo_len", 64'(cnt), 64'(TMO));
    check("tmo_resp", 64'(jtag_out_reg), 64'(model_resp(host_tog, 1'b0, 1'b1, 1'b1, 32'h0)));
    held = jtag_out_reg;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'h55AA55AA;
    @(negedge CLK);
    bus_if.bus_ack = 1'b0;
    @(negedge CLK);
    check("tmo_late_ack", 64'({bus_if.bus_req, jtag_out_reg}), 64'({1'b0, held}));
`else
    cnt = 0;
    held = '0;
    run_access("long", 1'b1, 16'h0100, 32'h0, 32'h0BADF00D, 20, 1'b0);
`endif

    // Reset during an access with the toggle left high.
    if (host_tog) run_access("align", 1'b0, 16'($urandom), 32'($urandom), 32'h0, 0, 1'b0);
    send_cmd(1'b1, 16'h0200, 32'h0);
    repeat (5) @(negedge CLK);
    check("mid_req", 64'(bus_if.bus_req), 64'd1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_req", 64'(bus_if.bus_req), 64'd0);
    check("mid_rst_bus", 64'({bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}), 64'd0);
    check("mid_rst_out", 64'(jtag_out_reg), 64'd0);
    bus_if.bus_ack = 1'b1;
    repeat (2) @(negedge CLK);
    bus_if.bus_ack = 1'b0;
    RST_N = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      bus_if.bus_ack = (i == 5 || i == 6);
      if (bus_if.bus_req !== 1'b0) ok = 1'b0;
    end
    bus_if.bus_ack = 1'b0;
    check("post_rst_quiet", 64'(ok), 64'd1);
    check("post_rst_out", 64'(jtag_out_reg), 64'd0);
    run_access("post_rst", 1'b1, 16'h0300, 32'h0, 32'hA5A5A5A5, 3, 1'b0);
    check("post_rst_tog", 64'(jtag_out_reg[DW+2]), 64'd0);
    ok = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (bus_if.bus_req !== 1'b0) ok = 1'b0;
    end
    check("post_rst_single", 64'(ok), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtag_reg_bridge.md
JTAG_REG_BRIDGE -- requirements
Module: jtag_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, ack wait limit in CLK cycles.
REQ-004 SHALL have CLK, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have RST_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have jtag_in_reg, input, ADDR_W+DATA_W+2, asynchronous command word from the JTAG user register: [MSB] cmd_toggle, [MSB-1] rnw, then addr, then wdata in the LSBs.
REQ-007 SHALL have jtag_out_reg, output, DATA_W+3, response word to the JTAG user register: [MSB] resp_toggle, then overrun, then err, then rdata in the LSBs.
REQ-008 SHALL have bus_req, output, 1, access request.
REQ-009 SHALL have bus_we, output, 1, write when high.
REQ-010 SHALL have bus_addr, output, ADDR_W, access address.
REQ-011 SHALL have bus_wdata, output, DATA_W, write data.
REQ-012 SHALL have bus_ack, input, 1, access complete.
REQ-013 SHALL have bus_rdata, input, DATA_W, read data, valid with bus_ack.

Function
REQ-014 SHALL pass all jtag_in_reg bits through two CLK synchronizer stages (s1, s2), and cmd_toggle through a third stage (s3).
REQ-015 SHALL detect a new command when s2 toggle differs from s3 toggle; it SHALL take fields from s2. The host holds the word stable until resp_toggle matches.
REQ-016 SHALL implement FSM IDLE -> REQ -> IDLE; IDLE moves to REQ on a new command, or on a pending command.
REQ-017 Latency: for a toggle change sampled at edge N, bus_req SHALL be high after edge N+2. bus_we, bus_addr and bus_wdata SHALL be registered and stable while bus_req is high.
REQ-018 bus_req SHALL stay high until bus_ack is sampled high at edge M. At M, bus_req SHALL drop and the FSM SHALL return to IDLE.
REQ-019 At M, jtag_out_reg SHALL update in one edge: rdata = bus_rdata for a read and 0 for a write, err = 0, and resp_toggle set to the command's toggle value.
REQ-020 bus_ack SHALL be ignored outside REQ.
REQ-021 A new command detected while in REQ SHALL set a one-deep pending flag, which is issued on return to IDLE.
REQ-022 A further new command while pending is set SHALL be dropped and SHALL set the sticky overrun bit. A host read of the status (any completed command) SHALL clear overrun after reporting it once.
REQ-023 Detection SHALL be suppressed for the first 3 CLK edges after reset release, with s3 tracking s2, so no spurious command is issued.

Reset
REQ-024 On RST_N low, all outputs SHALL go to 0 asynchronously: bus_req, bus_we, bus_addr, bus_wdata and jtag_out_reg.
REQ-025 On RST_N low, the FSM SHALL go to IDLE and the pending flag, overrun bit, synchronizers and timeout counter SHALL clear.
REQ-026 Reset asserted mid-REQ SHALL abort the access with no response update; a later bus_ack SHALL be ignored.

Configuration
REQ-027 With JTAG_BRIDGE_TIMEOUT_EN defined, a counter SHALL run in REQ.
REQ-028 With JTAG_BRIDGE_TIMEOUT_EN defined, after TIMEOUT_CYCLES edges without ack the block SHALL drop bus_req, return to IDLE and respond with err = 1, rdata all-ones and resp_toggle updated.
REQ-029 Without JTAG_BRIDGE_TIMEOUT_EN, there SHALL be no counter, REQ SHALL wait indefinitely and err SHALL be constant 0.

Structure
REQ-030 Package jtag_bridge_pkg SHALL hold the FSM state enum and the command/response field offset and width constants.
REQ-031 Sub-module jtag_bridge_sync SHALL be a parameterized-width two-stage synchronizer with async reset to 0.

Verification
REQ-032 Read: addr 0x0010 with toggle 0->1; bus_ack after 4 cycles with rdata 0x12345678 -> bus_req seen at N+2 for exactly 5 cycles; jtag_out_reg = {1,0,0,0x12345678}.
REQ-033 Write: wdata 0xCAFEF00D to 0x0004 -> bus_we = 1 with matching addr/data; response rdata = 0, resp_toggle = cmd_toggle.
REQ-034 Two toggles during one REQ, then a third -> second access issued back-to-back after the first; third dropped; overrun = 1 on the next response, then 0.
REQ-035 With JTAG_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no ack -> bus_req high for 8 cycles, then err = 1, rdata = 0xFFFFFFFF; a late ack is ignored.
REQ-036 RST_N pulsed low mid-REQ with cmd_toggle held at 1 -> all outputs 0 immediately; no command issued after release; the next toggle to 0 issues exactly one access.
